// File: rtl/instr_readback_engine_if.sv
// Bundle between the readback engine, the instruction register read port and
// the record consumer. The engine side uses the master modport.
interface instr_readback_engine_if #(
   parameter int CNT_W = 16
);

   typedef struct packed {
      logic        [3:0]  opc;
      logic signed [31:0] op_a;
      logic signed [31:0] op_b;
      logic signed [63:0] rezultat;
   } instruction_t;

   logic                     start;
   logic                     start_ready;
   logic        [4:0]        start_addr;
   logic        [5:0]        count;
   logic        [1:0]        order_mode;
   logic        [4:0]        read_pointer;
   instruction_t             instruction_word;
   logic                     out_valid;
   logic                     out_ready;
   logic        [4:0]        out_addr;
   instruction_t             out_word;
   logic signed [63:0]       out_expected;
   logic                     out_match;
   logic                     busy;
   logic                     done;
   logic        [CNT_W-1:0]  pass_count;
   logic        [CNT_W-1:0]  total_count;

   modport master (
      input  start, start_addr, count, order_mode, instruction_word, out_ready,
      output start_ready, read_pointer, out_valid, out_addr, out_word, out_expected,
             out_match, busy, done, pass_count, total_count
   );

   modport slave (
      output start, start_addr, count, order_mode, instruction_word, out_ready,
      input  start_ready, read_pointer, out_valid, out_addr, out_word, out_expected,
             out_match, busy, done, pass_count, total_count
   );

endinterface

// File: rtl/instr_readback_engine.sv
// Readback sequencer for instr_register: walks read_pointer over a range,
// captures each word, recomputes the ALU result and streams records out.
module instr_readback_engine #(
   parameter int RD_LATENCY = 0,
   parameter int CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   instr_readback_engine_if.master bus
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_READ    = 2'd1;
   localparam logic [1:0] S_PRESENT = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   localparam logic [3:0] OP_ZERO  = 4'd0;
   localparam logic [3:0] OP_PASSA = 4'd1;
   localparam logic [3:0] OP_PASSB = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_MULT  = 4'd5;
   localparam logic [3:0] OP_DIV   = 4'd6;
   localparam logic [3:0] OP_MOD   = 4'd7;

   localparam logic [1:0] WAIT_LAST = RD_LATENCY[1:0];
   localparam logic [5:0] MAX_COUNT = 6'd32;
   localparam int         WORD_W    = 132;

   // Reference ALU: operands sign-extended, divide/modulo by zero give 0.
   function automatic logic signed [63:0] calc_expected(
      input logic        [3:0]  opc,
      input logic signed [31:0] op_a,
      input logic signed [31:0] op_b
   );
      logic signed [63:0] a64;
      logic signed [63:0] b64;
      logic signed [63:0] res;
      a64 = {{32{op_a[31]}}, op_a};
      b64 = {{32{op_b[31]}}, op_b};
      case (opc)
         OP_ZERO:  res = '0;
         OP_PASSA: res = a64;
         OP_PASSB: res = b64;
         OP_ADD:   res = a64 + b64;
         OP_SUB:   res = a64 - b64;
         OP_MULT:  res = a64 * b64;
         OP_DIV:   res = (b64 == 64'sd0) ? 64'sd0 : a64 / b64;
         OP_MOD:   res = (b64 == 64'sd0) ? 64'sd0 : a64 % b64;
         default:  res = '0;
      endcase
      return res;
   endfunction

   // Counter increment that sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Address sequence: up, down, or Fibonacci LFSR x^5+x^3+1 (taps 5 and 3).
   function automatic logic [4:0] next_addr(input logic [1:0] mode, input logic [4:0] addr);
      case (mode)
         2'd1:    return addr - 5'd1;
         2'd2:    return {addr[3:0], addr[4] ^ addr[2]};
         default: return addr + 5'd1;
      endcase
   endfunction

   // The LFSR locks up at zero, so a zero seed becomes 1.
   function automatic logic [4:0] seed_addr(input logic [1:0] mode, input logic [4:0] addr);
      return (mode == 2'd2 && addr == 5'd0) ? 5'd1 : addr;
   endfunction

   logic        [1:0]        state;
   logic        [1:0]        mode;
   logic        [5:0]        remaining;
   logic        [1:0]        wait_cnt;
   logic        [4:0]        ptr;
   logic        [CNT_W-1:0]  pass_cnt;
   logic        [CNT_W-1:0]  total_cnt;

   logic        [5:0]        count_clip;
   logic                     accept;
   logic                     capture;
   logic                     handshake;

   logic signed [63:0]       expected_p0;
   logic                     match_p0;

   logic        [4:0]        addr_p1;
   logic        [WORD_W-1:0] word_p1;
   logic signed [63:0]       expected_p1;
   logic                     match_p1;

   assign count_clip = (bus.count > MAX_COUNT) ? MAX_COUNT : bus.count;
   assign accept     = (state == S_IDLE) && bus.start;
   assign capture    = (state == S_READ) && (wait_cnt == WAIT_LAST);
   assign handshake  = (state == S_PRESENT) && bus.out_ready;

   assign expected_p0 = calc_expected(bus.instruction_word.opc,
                                      bus.instruction_word.op_a,
                                      bus.instruction_word.op_b);
   assign match_p0    = (expected_p0 == bus.instruction_word.rezultat);

   // Scan control: state, address walk, remaining records and counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         mode      <= 2'd0;
         remaining <= 6'd0;
         wait_cnt  <= 2'd0;
         ptr       <= 5'h1F;
         pass_cnt  <= '0;
         total_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  mode      <= bus.order_mode;
                  remaining <= count_clip;
                  ptr       <= seed_addr(bus.order_mode, bus.start_addr);
                  wait_cnt  <= 2'd0;
                  pass_cnt  <= '0;
                  total_cnt <= '0;
                  state     <= (bus.count == 6'd0) ? S_DONE : S_READ;
               end
            end
            S_READ: begin
               if (capture) begin
                  total_cnt <= sat_inc(total_cnt);
                  if (match_p0) pass_cnt <= sat_inc(pass_cnt);
                  remaining <= remaining - 6'd1;
                  state     <= S_PRESENT;
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            S_PRESENT: begin
               if (handshake) begin
                  ptr      <= next_addr(mode, ptr);
                  wait_cnt <= 2'd0;
                  state    <= (remaining == 6'd0) ? S_DONE : S_READ;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // ---- capture stage: record registers, held until the next capture ----
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_p1     <= 5'd0;
         word_p1     <= '0;
         expected_p1 <= '0;
         match_p1    <= 1'b0;
      end else if (capture) begin
         addr_p1     <= ptr;
         word_p1     <= bus.instruction_word;
         expected_p1 <= expected_p0;
         match_p1    <= match_p0;
      end
   end

   assign bus.start_ready  = (state == S_IDLE);
   assign bus.busy         = (state != S_IDLE);
   assign bus.done         = (state == S_DONE);
   assign bus.out_valid    = (state == S_PRESENT);
   assign bus.read_pointer = ptr;
   assign bus.out_addr     = addr_p1;
   assign bus.out_word     = word_p1;
   assign bus.out_expected = expected_p1;
   assign bus.out_match    = match_p1;
   assign bus.pass_count   = pass_cnt;
   assign bus.total_count  = total_cnt;

endmodule

// File: tb/tb_instr_readback_engine.sv
// Directed bench for instr_readback_engine: one DUT with combinational reads,
// one with a two-cycle read latency, both fed from a shared instruction memory.
module tb_instr_readback_engine;

   localparam int CNT_W = 16;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_MULT = 4'd5;
   localparam logic [3:0] OP_DIV  = 4'd6;
   localparam logic [3:0] OP_MOD  = 4'd7;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        out_ready;
   logic        sel;
   logic [4:0]  start_addr;
   logic [5:0]  count;
   logic [1:0]  order_mode;
   logic [131:0] mem [32];
   logic [131:0] d1, d2;

   int vec  = 0;
   int miss = 0;

   // scan recorder results
   int                 n_rec, n_done, done_cyc;
   logic [4:0]         ptr_at1;
   logic               busy_at1, busy_after, done_after;
   logic [4:0]         rec_addr  [40];
   logic signed [63:0] rec_exp   [40];
   logic               rec_match [40];
   int                 rec_cyc   [40];

   instr_readback_engine_if #(.CNT_W(CNT_W)) ifc0 ();
   instr_readback_engine_if #(.CNT_W(CNT_W)) ifc2 ();

   instr_readback_engine #(.RD_LATENCY(0), .CNT_W(CNT_W)) dut0 (.clk(clk), .reset(reset), .bus(ifc0));
   instr_readback_engine #(.RD_LATENCY(2), .CNT_W(CNT_W)) dut2 (.clk(clk), .reset(reset), .bus(ifc2));

   always #5 clk = ~clk;

   assign ifc0.start      = start & ~sel;
   assign ifc2.start      = start & sel;
   assign ifc0.start_addr = start_addr;
   assign ifc2.start_addr = start_addr;
   assign ifc0.count      = count;
   assign ifc2.count      = count;
   assign ifc0.order_mode = order_mode;
   assign ifc2.order_mode = order_mode;
   assign ifc0.out_ready  = out_ready;
   assign ifc2.out_ready  = out_ready;

   assign ifc0.instruction_word = mem[ifc0.read_pointer];
   always @(posedge clk) begin
      d1 <= mem[ifc2.read_pointer];
      d2 <= d1;
   end
   assign ifc2.instruction_word = d2;

   logic               obs_valid, obs_done, obs_busy, obs_match;
   logic [4:0]         obs_addr, obs_ptr;
   logic signed [63:0] obs_exp;
   logic [CNT_W-1:0]   obs_pass, obs_total;
   assign obs_valid = sel ? ifc2.out_valid    : ifc0.out_valid;
   assign obs_done  = sel ? ifc2.done         : ifc0.done;
   assign obs_busy  = sel ? ifc2.busy         : ifc0.busy;
   assign obs_match = sel ? ifc2.out_match    : ifc0.out_match;
   assign obs_addr  = sel ? ifc2.out_addr     : ifc0.out_addr;
   assign obs_ptr   = sel ? ifc2.read_pointer : ifc0.read_pointer;
   assign obs_exp   = sel ? ifc2.out_expected : ifc0.out_expected;
   assign obs_pass  = sel ? ifc2.pass_count   : ifc0.pass_count;
   assign obs_total = sel ? ifc2.total_count  : ifc0.total_count;

   function automatic logic [131:0] mk(input logic [3:0] opc, input logic signed [31:0] a,
                                       input logic signed [31:0] b, input logic signed [63:0] r);
      return {opc, a, b, r};
   endfunction

   task automatic fill_ramp();
      for (int i = 0; i < 32; i++) mem[i] = mk(OP_ADD, i, 100, 64'(i + 100));
   endtask

   // Start a scan with out_ready high and record every record and done pulse.
   task automatic run_scan(input logic [4:0] a, input logic [5:0] c, input logic [1:0] m, input int budget);
      int cyc;
      n_rec = 0; n_done = 0; done_cyc = -1;
      start_addr = a; count = c; order_mode = m; out_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      ptr_at1 = obs_ptr;
      busy_at1 = obs_busy;
      while (cyc <= budget && n_done == 0) begin
         if (obs_valid && n_rec < 40) begin
            rec_addr[n_rec] = obs_addr; rec_exp[n_rec] = obs_exp;
            rec_match[n_rec] = obs_match; rec_cyc[n_rec] = cyc;
            n_rec++;
         end
         if (obs_done) begin n_done++; done_cyc = cyc; end
         @(negedge clk);
         cyc++;
      end
      busy_after = obs_busy;
      done_after = obs_done;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      vec++; if (ifc0.read_pointer !== 5'd31) begin miss++; $display("FAIL reset_ptr: got %0d want 31", ifc0.read_pointer); end
      vec++; if (ifc0.out_valid !== 1'b0) begin miss++; $display("FAIL reset_valid: got %b want 0", ifc0.out_valid); end
      vec++; if (ifc0.busy !== 1'b0) begin miss++; $display("FAIL reset_busy: got %b want 0", ifc0.busy); end
      vec++; if (ifc0.start_ready !== 1'b1) begin miss++; $display("FAIL reset_start_ready: got %b want 1", ifc0.start_ready); end
      vec++; if (ifc0.done !== 1'b0) begin miss++; $display("FAIL reset_done: got %b want 0", ifc0.done); end
      vec++; if (ifc0.pass_count !== 16'd0 || ifc0.total_count !== 16'd0) begin miss++; $display("FAIL reset_counters: got %0d/%0d want 0/0", ifc0.pass_count, ifc0.total_count); end
      vec++; if (ifc0.out_match !== 1'b0 || ifc0.out_addr !== 5'd0 || ifc0.out_expected !== 64'sd0) begin miss++; $display("FAIL reset_record: got match %b addr %0d exp %0d want 0", ifc0.out_match, ifc0.out_addr, ifc0.out_expected); end
      vec++; if (ifc2.read_pointer !== 5'd31 || ifc2.busy !== 1'b0) begin miss++; $display("FAIL reset_dut2: got ptr %0d busy %b want 31 0", ifc2.read_pointer, ifc2.busy); end
   endtask

   task automatic test_mode0_wrap();
      logic [4:0] want_addr [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
      for (int i = 0; i < 32; i++) mem[i] = mk(OP_ADD, 5, -3, 64'sd2);
      sel = 1'b0;
      run_scan(5'd30, 6'd4, 2'd0, 40);
      vec++; if (ptr_at1 !== 5'd30 || busy_at1 !== 1'b1) begin miss++; $display("FAIL m0_start: got ptr %0d busy %b want 30 1", ptr_at1, busy_at1); end
      vec++; if (n_rec !== 4) begin miss++; $display("FAIL m0_records: got %0d want 4", n_rec); end
      for (int i = 0; i < 4 && i < n_rec; i++) begin
         vec++; if (rec_addr[i] !== want_addr[i] || rec_match[i] !== 1'b1 || rec_exp[i] !== 64'sd2) begin miss++; $display("FAIL m0_rec%0d: got addr %0d match %b exp %0d want %0d 1 2", i, rec_addr[i], rec_match[i], rec_exp[i], want_addr[i]); end
         vec++; if (rec_cyc[i] !== 2 + 2 * i) begin miss++; $display("FAIL m0_cycle%0d: got %0d want %0d", i, rec_cyc[i], 2 + 2 * i); end
      end
      vec++; if (n_done !== 1 || done_cyc !== 9 || done_after !== 1'b0) begin miss++; $display("FAIL m0_done: got n %0d cyc %0d after %b want 1 9 0", n_done, done_cyc, done_after); end
      vec++; if (busy_after !== 1'b0) begin miss++; $display("FAIL m0_busy_after: got %b want 0", busy_after); end
      vec++; if (obs_pass !== 16'd4 || obs_total !== 16'd4) begin miss++; $display("FAIL m0_counters: got %0d/%0d want 4/4", obs_pass, obs_total); end
   endtask

   task automatic test_mode1();
      logic [4:0] want_addr [3] = '{5'd1, 5'd0, 5'd31};
      fill_ramp();
      sel = 1'b0;
      run_scan(5'd1, 6'd3, 2'd1, 20);
      vec++; if (n_rec !== 3 || n_done !== 1) begin miss++; $display("FAIL m1_records: got %0d recs %0d dones want 3 1", n_rec, n_done); end
      for (int i = 0; i < 3 && i < n_rec; i++) begin
         vec++; if (rec_addr[i] !== want_addr[i]) begin miss++; $display("FAIL m1_addr%0d: got %0d want %0d", i, rec_addr[i], want_addr[i]); end
      end
   endtask

   task automatic test_lfsr();
      logic [31:0] seen;
      int          distinct;
      seen = '0;
      distinct = 0;
      sel = 1'b0;
      run_scan(5'd0, 6'd31, 2'd2, 100);
      vec++; if (n_rec !== 31) begin miss++; $display("FAIL lfsr_records: got %0d want 31", n_rec); end
      vec++; if (ptr_at1 !== 5'd1 || rec_addr[0] !== 5'd1) begin miss++; $display("FAIL lfsr_seed: got ptr %0d first %0d want 1 1", ptr_at1, rec_addr[0]); end
      for (int i = 0; i < n_rec; i++) seen[rec_addr[i]] = 1'b1;
      for (int i = 0; i < 32; i++) if (seen[i]) distinct++;
      vec++; if (distinct !== 31 || seen[0] !== 1'b0) begin miss++; $display("FAIL lfsr_cover: got %0d distinct zero_seen %b want 31 0", distinct, seen[0]); end
   endtask

   task automatic test_expected();
      logic signed [63:0] want_exp [6] = '{64'sd0, -64'sd225, -64'sd30, -64'sd1, 64'sd0, -64'sd3};
      logic               want_m   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      fill_ramp();
      mem[4] = mk(OP_DIV, 7, 0, 64'sd0);
      mem[5] = mk(OP_MULT, -15, 15, 64'sd0);
      mem[6] = mk(OP_SUB, -15, 15, -64'sd30);
      mem[7] = mk(OP_MOD, -7, 2, -64'sd1);
      mem[8] = mk(4'd12, 3, 4, 64'sd0);
      mem[9] = mk(OP_DIV, -7, 2, -64'sd3);
      sel = 1'b0;
      run_scan(5'd4, 6'd6, 2'd0, 30);
      vec++; if (n_rec !== 6) begin miss++; $display("FAIL exp_records: got %0d want 6", n_rec); end
      for (int i = 0; i < 6 && i < n_rec; i++) begin
         vec++; if (rec_exp[i] !== want_exp[i] || rec_match[i] !== want_m[i]) begin miss++; $display("FAIL exp_rec%0d: got %0d match %b want %0d match %b", i, rec_exp[i], rec_match[i], want_exp[i], want_m[i]); end
      end
      vec++; if (obs_pass !== 16'd5 || obs_total !== 16'd6) begin miss++; $display("FAIL exp_counters: got %0d/%0d want 5/6", obs_pass, obs_total); end
   endtask

   task automatic test_backpressure();
      int hs_addr [2];
      int nh, nd;
      fill_ramp();
      sel = 1'b0;
      start_addr = 5'd10; count = 6'd2; order_mode = 2'd0; out_ready = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10 && !ifc0.out_valid; i++) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         vec++; if (ifc0.out_valid !== 1'b1 || ifc0.out_addr !== 5'd10 || ifc0.read_pointer !== 5'd10) begin miss++; $display("FAIL bp_hold%0d: got valid %b addr %0d ptr %0d want 1 10 10", k, ifc0.out_valid, ifc0.out_addr, ifc0.read_pointer); end
         vec++; if (ifc0.out_expected !== 64'sd110 || ifc0.out_word.rezultat !== 64'sd110 || ifc0.out_word.op_a !== 32'sd10) begin miss++; $display("FAIL bp_data%0d: got exp %0d rez %0d a %0d want 110 110 10", k, ifc0.out_expected, ifc0.out_word.rezultat, ifc0.out_word.op_a); end
         if (k == 2) begin start_addr = 5'd20; count = 6'd1; start = 1'b1; end
         else start = 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      out_ready = 1'b1;
      nh = 0; nd = 0;
      for (int i = 0; i < 20; i++) begin
         if (ifc0.out_valid && nh < 2) begin hs_addr[nh] = int'(ifc0.out_addr); nh++; end
         if (ifc0.done) nd++;
         @(negedge clk);
      end
      vec++; if (nh !== 2 || hs_addr[0] !== 10 || hs_addr[1] !== 11) begin miss++; $display("FAIL bp_stream: got %0d recs first %0d second %0d want 2 10 11", nh, hs_addr[0], hs_addr[1]); end
      vec++; if (nd !== 1 || ifc0.busy !== 1'b0 || ifc0.out_valid !== 1'b0) begin miss++; $display("FAIL bp_start_ignored: got dones %0d busy %b valid %b want 1 0 0", nd, ifc0.busy, ifc0.out_valid); end
      vec++; if (ifc0.total_count !== 16'd2) begin miss++; $display("FAIL bp_total: got %0d want 2", ifc0.total_count); end
   endtask

   task automatic test_reset_mid();
      int hs, nd;
      fill_ramp();
      sel = 1'b0;
      start_addr = 5'd0; count = 6'd8; order_mode = 2'd0; out_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hs = 0;
      for (int i = 0; i < 40 && hs < 2; i++) begin
         if (ifc0.out_valid) hs++;
         @(negedge clk);
      end
      vec++; if (hs !== 2 || ifc0.total_count !== 16'd2 || ifc0.busy !== 1'b1) begin miss++; $display("FAIL rmid_pre: got hs %0d total %0d busy %b want 2 2 1", hs, ifc0.total_count, ifc0.busy); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vec++; if (ifc0.start_ready !== 1'b1 || ifc0.busy !== 1'b0 || ifc0.out_valid !== 1'b0) begin miss++; $display("FAIL rmid_idle: got ready %b busy %b valid %b want 1 0 0", ifc0.start_ready, ifc0.busy, ifc0.out_valid); end
      vec++; if (ifc0.pass_count !== 16'd0 || ifc0.total_count !== 16'd0 || ifc0.read_pointer !== 5'd31) begin miss++; $display("FAIL rmid_state: got %0d/%0d ptr %0d want 0/0 31", ifc0.pass_count, ifc0.total_count, ifc0.read_pointer); end
      nd = 0;
      for (int i = 0; i < 6; i++) begin
         if (ifc0.done) nd++;
         @(negedge clk);
      end
      vec++; if (nd !== 0) begin miss++; $display("FAIL rmid_no_done: got %0d want 0", nd); end
   endtask

   task automatic test_latency2();
      fill_ramp();
      sel = 1'b1;
      run_scan(5'd3, 6'd2, 2'd0, 30);
      vec++; if (ptr_at1 !== 5'd3 || n_rec !== 2) begin miss++; $display("FAIL lat2_setup: got ptr %0d recs %0d want 3 2", ptr_at1, n_rec); end
      vec++; if (rec_cyc[0] !== 4 || rec_addr[0] !== 5'd3 || rec_exp[0] !== 64'sd103) begin miss++; $display("FAIL lat2_first: got cyc %0d addr %0d exp %0d want 4 3 103", rec_cyc[0], rec_addr[0], rec_exp[0]); end
      vec++; if (rec_cyc[1] !== 8 || rec_addr[1] !== 5'd4) begin miss++; $display("FAIL lat2_second: got cyc %0d addr %0d want 8 4", rec_cyc[1], rec_addr[1]); end
      vec++; if (n_done !== 1 || done_cyc !== 9) begin miss++; $display("FAIL lat2_done: got n %0d cyc %0d want 1 9", n_done, done_cyc); end
      sel = 1'b0;
   endtask

   task automatic test_count_edges();
      sel = 1'b0;
      run_scan(5'd7, 6'd0, 2'd0, 10);
      vec++; if (n_done !== 1 || done_cyc !== 1 || n_rec !== 0) begin miss++; $display("FAIL cnt0: got dones %0d cyc %0d recs %0d want 1 1 0", n_done, done_cyc, n_rec); end
      vec++; if (busy_at1 !== 1'b1 || busy_after !== 1'b0 || obs_total !== 16'd0) begin miss++; $display("FAIL cnt0_busy: got %b %b total %0d want 1 0 0", busy_at1, busy_after, obs_total); end
      fill_ramp();
      run_scan(5'd0, 6'd40, 2'd0, 100);
      vec++; if (n_rec !== 32 || obs_total !== 16'd32 || rec_addr[31] !== 5'd31) begin miss++; $display("FAIL clip32: got recs %0d total %0d last %0d want 32 32 31", n_rec, obs_total, rec_addr[31]); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; out_ready = 1'b0; sel = 1'b0;
      start_addr = 5'd0; count = 6'd0; order_mode = 2'd0;
      fill_ramp();
      test_reset();
      test_mode0_wrap();
      test_mode1();
      test_lfsr();
      test_expected();
      test_backpressure();
      test_reset_mid();
      test_latency2();
      test_count_edges();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/instr_readback_engine.md
# instr_readback_engine

Sequencer that sits directly downstream of `instr_register`. It walks `read_pointer` over a programmed address range and captures each `instruction_word`. It recomputes the expected ALU result from the captured opcode and operands, then streams each record out over a valid/ready handshake. It also keeps pass and total counters, so a hardware scan gives the same self-check as the bench.

## Interface
Parameters:
- RD_LATENCY, 0: cycles from `read_pointer` change to a valid `instruction_word` (0 = combinational read); legal 0..3.
- CNT_W, 16: width of pass/total counters.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a scan; accepted only when `start_ready`=1.
- start_ready  out  1  high in IDLE only.
- start_addr  in  5  first address (address_t).
- count  in  6  records to read; 0 = empty scan, values >32 clipped to 32.
- order_mode  in  2  0 incrementing, 1 decrementing, 2 LFSR, 3 same as 0.
- read_pointer  out  5  drives `instr_register`.
- instruction_word  in  instruction_t  opc (4b), op_a/op_b (32b signed), rezultat (64b signed).
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts record.
- out_addr  out  5  address the record was read from.
- out_word  out  instruction_t  captured word.
- out_expected  out  64  recomputed result, signed.
- out_match  out  1  `out_expected === out_word.rezultat`.
- busy  out  1  scan in progress; the writer must hold `load_en`=0 while busy.
- done  out  1  one-cycle pulse at scan end.
- pass_count, total_count  out  CNT_W  saturating counters.

## Operation
- FSM states: IDLE, READ, PRESENT, DONE.
- IDLE, on `start`:
  - latch mode and clipped count into `remaining`;
  - load pointer = `start_addr`;
  - clear both counters;
  - go to READ, or to DONE if `count`=0.
- READ: `read_pointer` holds the current address. A wait counter runs RD_LATENCY cycles. At the end of the wait, on that edge:
  - capture `instruction_word`, the address and the expected result;
  - increment `total_count`, and `pass_count` on match;
  - decrement `remaining`;
  - go to PRESENT.
- PRESENT: `out_valid`=1 with all outputs stable. On `out_valid && out_ready`:
  - advance the pointer;
  - go to DONE if `remaining`=0, else to READ.
- DONE: `done`=1 for one cycle, then IDLE.
- Pointer advance and wrap:
  - mode 0: +1 mod 32 (31→0);
  - mode 1: −1 mod 32 (0→31);
  - mode 2: 5-bit Fibonacci LFSR, x^5+x^3+1, seeded with `start_addr`; seed 0 is replaced by 1, and address 0 is never visited in this mode.
- Expected result, all operations signed, operands sign-extended to 64 bits:
  - ZERO: 0; PASSA: op_a; PASSB: op_b;
  - ADD: op_a+op_b; SUB: op_a−op_b; MULT: full 64-bit product;
  - DIV: op_a/op_b, truncated toward zero, or 0 if op_b=0;
  - MOD: op_a%op_b, sign of dividend, or 0 if op_b=0;
  - undefined opcodes: 0.
- Counters saturate at all-ones.
- Both counters hold their values after DONE until the next accepted start.
- `start` while busy is ignored.

## Timing
- Reset values:
  - state IDLE, `start_ready`=1, `read_pointer`=5'h1F;
  - `out_valid`=0, `busy`=0, `done`=0, `out_match`=0;
  - `out_addr`/`out_word`/`out_expected` =0, counters 0.
- Reset asserted mid-scan: reset values take effect at the next edge, any pending record is dropped, and no `done` is produced.
- Start accepted at edge T → `read_pointer` = `start_addr` and `busy`=1 from T+1.
- First `out_valid` appears at T+2+RD_LATENCY.
- Throughput: with `out_ready` held high, one record every 2+RD_LATENCY cycles.
- `read_pointer` changes only on the accepting handshake edge; it is stable through the wait and PRESENT.
- `out_*` stay stable while `out_valid && !out_ready`.
- `done` pulses in the cycle after the last handshake; `busy` falls together with `done`.
- `count`=0: `done` pulses at T+1 and no records are produced.

## Test plan
- Reset held 2 cycles → `read_pointer`=31, `out_valid`=0, `busy`=0, `start_ready`=1, counters 0.
- Mode 0, start_addr 30, count 4, all locations ADD 5,−3, rezultat 2 → records from addresses 30,31,0,1, all `out_match`=1, pass=total=4, single `done` pulse.
- Mode 1, start_addr 1, count 3 → addresses 1,0,31. With mode 2 and seed 0, count 31 → 31 distinct nonzero addresses.
- Expected-result checks:
  - DIV 7/0 with rezultat 0 → expected 0, match;
  - MULT −15·15 with rezultat 0 → expected −225, `out_match`=0, pass=total−1;
  - SUB −15−15 → −30.
- Backpressure: `out_ready` low for 5 cycles → `out_valid` and data stable, `read_pointer` stable; a `start` pulse during this window is ignored.
- Reset after 2 handshakes of a count-8 scan → IDLE next cycle, counters 0, no `done`. Repeat with RD_LATENCY=2 and check first-record latency T+4.
